multi_pattern_generator: RTL

//  Parametrised successor of the debug colour-bar generator. Streams complete
//  RGB565 test frames into the 17-bit LCD/framebuffer FIFO, honouring queue_full.

---
 rtl/pattern_pkg.sv | 24 ++
 rtl/pattern_pixel_gen.sv | 45 ++++
 rtl/multi_pattern_generator.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// Shared definitions for the multi-pattern test-frame generator.
//  pattern_mode_t : runtime pattern selector (BARS, GRADIENT, CHECKER, SOLID)
//  BAR_PALETTE    : eight RGB565 colours cycled by the colour-bar pattern
//  SOF_BIT        : bit of the 17-bit FIFO word that flags pixel (0,0)
//  COORD_W        : width of the coordinate buses into the pixel function
package pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_GRADIENT = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_SOLID    = 2'd3
  } pattern_mode_t;

  localparam int SOF_BIT = 16;
  localparam int COORD_W = 16;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [15:0] BAR_PALETTE [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

endpackage

// File: rtl/pattern_pixel_gen.sv
// Combinational pixel function: maps (mode, x, y, bar index, solid colour)
// to one RGB565 value.
//  mode    in  pattern selector
//  x, y    in  pixel coordinates (zero-extended)
//  bar_idx in  current colour-bar index (only bits [2:0] select the colour)
//  solid   in  colour used in SOLID mode
//  pixel   out RGB565 result
module pattern_pixel_gen
  import pattern_pkg::*;
#(
  parameter int CHECKER_SHIFT = 4
) (
  input  pattern_mode_t        mode,
  input  logic [COORD_W-1:0]   x,
  input  logic [COORD_W-1:0]   y,
  input  logic [COORD_W-1:0]   bar_idx,
  input  logic [15:0]          solid,
  output logic [15:0]          pixel
);

  logic [9:0]         sum;
  logic [COORD_W-1:0] x_sq;
  logic [COORD_W-1:0] y_sq;
  logic               unused_bits;

  // The gradient sum is deliberately truncated to 10 bits.
  assign sum  = x[9:0] + y[9:0];
  assign x_sq = x >> CHECKER_SHIFT;
  assign y_sq = y >> CHECKER_SHIFT;

  // Coordinate bits the pixel function does not look at.
  assign unused_bits = ^{x, y, bar_idx, sum, x_sq, y_sq};

  always_comb begin
    pixel = 16'h0000;
    case (mode)
      MODE_BARS:     pixel = BAR_PALETTE[bar_idx[2:0]];
      MODE_GRADIENT: pixel = {x[8:4], y[7:2], sum[8:4]};
      MODE_CHECKER:  pixel = (x_sq[0] ^ y_sq[0]) ? 16'h0000 : 16'hFFFF;
      MODE_SOLID:    pixel = solid;
      default:       pixel = 16'h0000;
    endcase
  end

endmodule

// File: rtl/multi_pattern_generator.sv
// Streams complete RGB565 test frames into the 17-bit LCD debug FIFO.
//  clk          in  pixel/write clock
//  reset_n      in  asynchronous active-low reset
//  enable       in  level; keep producing frames while high
//  mode         in  pattern_mode_t encoding, sampled at each frame start
//  solid_color  in  colour for SOLID mode, sampled at each frame start
//  queue_full   in  FIFO full; no write while high
//  queue_data   out {start-of-frame, RGB565}
//  queue_wr_en  out FIFO write strobe
//  frame_done   out one-cycle pulse after the last pixel of a frame
//  frame_count  out number of completed frames (wraps)
module multi_pattern_generator
  import pattern_pkg::*;
#(
  parameter int FRAME_WIDTH    = 480,
  parameter int FRAME_HEIGHT   = 272,
  parameter int NUM_COLOR_BARS = 10,
  parameter int CHECKER_SHIFT  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  input  logic        queue_full,
  output logic [16:0] queue_data,
  output logic        queue_wr_en,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int COL_W  = $clog2(FRAME_WIDTH);
  localparam int ROW_W  = $clog2(FRAME_HEIGHT);
  localparam int BAR_IW = (NUM_COLOR_BARS > 1) ? $clog2(NUM_COLOR_BARS) : 1;
  localparam int BAR_W  = FRAME_WIDTH / NUM_COLOR_BARS;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0]        state;
  logic              valid;
  pattern_mode_t     mode_q;
  logic [15:0]       solid_q;
  logic [COL_W-1:0]  col, nxt_col;
  logic [ROW_W-1:0]  row, nxt_row;
  logic [COL_W-1:0]  bar_cnt, nxt_bar_cnt;
  logic [BAR_IW-1:0] bar_idx, nxt_bar_idx;
  logic              write;
  logic              last_px;
  pattern_mode_t     gen_mode;
  logic [15:0]       gen_solid;
  logic [15:0]       gen_pixel;

  assign write       = valid & ~queue_full;
  assign queue_wr_en = write;
  assign last_px     = (col == COL_W'(FRAME_WIDTH - 1)) &&
                       (row == ROW_W'(FRAME_HEIGHT - 1));

  // Coordinates of the pixel to be registered next. In LOAD this is (0,0)
  // and the pattern inputs are taken straight from the ports, since the
  // latched copies only become valid on the same edge.
  always_comb begin
    nxt_col     = '0;
    nxt_row     = '0;
    nxt_bar_cnt = '0;
    nxt_bar_idx = '0;
    gen_mode    = pattern_mode_t'(mode);
    gen_solid   = solid_color;
    if (state != S_LOAD) begin
      gen_mode  = mode_q;
      gen_solid = solid_q;
      if (col == COL_W'(FRAME_WIDTH - 1)) begin
        nxt_row = row + ROW_W'(1);
      end else begin
        nxt_col = col + COL_W'(1);
        nxt_row = row;
        // Bar tracker: step every BAR_W pixels, saturate on the last bar so
        // any remainder columns repeat it.
        if (bar_cnt == COL_W'(BAR_W - 1)) begin
          nxt_bar_cnt = '0;
          nxt_bar_idx = (bar_idx == BAR_IW'(NUM_COLOR_BARS - 1)) ?
                        bar_idx : bar_idx + BAR_IW'(1);
        end else begin
          nxt_bar_cnt = bar_cnt + COL_W'(1);
          nxt_bar_idx = bar_idx;
        end
      end
    end
  end

  pattern_pixel_gen #(
    .CHECKER_SHIFT (CHECKER_SHIFT)
  ) u_pixel_gen (
    .mode    (gen_mode),
    .x       (COORD_W'(nxt_col)),
    .y       (COORD_W'(nxt_row)),
    .bar_idx (COORD_W'(nxt_bar_idx)),
    .solid   (gen_solid),
    .pixel   (gen_pixel)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      valid       <= 1'b0;
      mode_q      <= MODE_BARS;
      solid_q     <= 16'h0000;
      col         <= '0;
      row         <= '0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
      queue_data  <= '0;
      frame_done  <= 1'b0;
      frame_count <= 16'h0000;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) state <= S_LOAD;
        end
        S_LOAD: begin
          mode_q              <= pattern_mode_t'(mode);
          solid_q             <= solid_color;
          col                 <= nxt_col;
          row                 <= nxt_row;
          bar_cnt             <= nxt_bar_cnt;
          bar_idx             <= nxt_bar_idx;
          queue_data          <= {1'b1, gen_pixel};
          valid               <= 1'b1;
          state               <= S_STREAM;
        end
        S_STREAM: begin
          if (write) begin
            if (last_px) begin
              valid       <= 1'b0;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              state       <= enable ? S_LOAD : S_IDLE;
            end else begin
              col        <= nxt_col;
              row        <= nxt_row;
              bar_cnt    <= nxt_bar_cnt;
              bar_idx    <= nxt_bar_idx;
              queue_data <= {1'b0, gen_pixel};
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
